lsu_mem_ctrl: RTL
=================

// Module: lsu_mem_ctrl
// PURPOSE
// Data-memory access controller for the RV32I core. Sits between the execute stage and the data bus,
// next to the load/store alignment logic. Takes pre-aligned store data and byte enables in; returns the
// raw 32-bit read word for alignment/extension. Drives a req/gnt + rvalid bus and stalls the core while
// an access is outstanding; flags misaligned accesses and bus timeouts.
// PARAMETERS
// TIMEOUT_CYCLES  64   cycles allowed in REQ+WAIT before bus_err; legal range >= 2
// CNT_W  $clog2(TIMEOUT_CYCLES)  timeout counter width (derived, not overridden)
// PORTS
// clk           in   1   core clock; all state updates on rising edge
// rst           in   1   synchronous, active-high reset
// req_valid     in   1   core presents a load/store this cycle
// req_write     in   1   1 = store, 0 = load
// req_addr      in   32  byte address
// req_funct3    in   3   load/store funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
// req_wdata     in   32  store data, already lane-aligned
// req_be        in   4   store byte enables, already lane-aligned
// stall         out  1   hold the core; access not yet complete
// resp_valid    out  1   one-cycle pulse: access finished (ok, misaligned or error)
// resp_rdata    out  32  raw read word; valid with resp_valid on a successful load
// misalign_exc  out  1   with resp_valid: misaligned or illegal funct3; no bus access was made
// bus_err       out  1   with resp_valid: timeout expired
// mem_req       out  1   bus request
// mem_we        out  1   bus write
// mem_addr      out  32  word address, {req_addr[31:2],2'b00}
// mem_wdata     out  32  store data
// mem_be        out  4   byte enables; loads drive 4'b1111
// mem_gnt       in   1   bus accepts request this cycle
// mem_rvalid    in   1   read data valid; arrives >= 1 cycle after gnt
// mem_rdata     in   32  read data
// BEHAVIOUR
// - FSM states: IDLE, REQ, WAIT, DONE. Reset: IDLE; counter 0; resp_rdata 0; all outputs 0.
// - IDLE, req_valid=1:
//   - misaligned (H/HU with addr[0]=1, W with addr[1:0]!=0) or funct3 not in the legal set
//     -> set misalign_exc flag, go to DONE, no mem_req.
//   - otherwise latch addr/we/wdata/be -> REQ.
// - REQ: mem_req=1. Fields come from the latched copy and stay stable until gnt.
//   - gnt on a write -> DONE. Writes are posted and complete on grant.
//   - gnt on a read -> WAIT.
// - WAIT: on mem_rvalid, capture mem_rdata into resp_rdata -> DONE. rvalid outside WAIT is ignored.
// - Timeout: counter clears on entering REQ and increments every cycle in REQ/WAIT.
//   - At TIMEOUT_CYCLES-1 without progress: set bus_err flag, drop mem_req, go to DONE.
//   - A gnt/rvalid in that same cycle wins over the timeout.
// - DONE: resp_valid=1 for exactly one cycle, with the misalign_exc/bus_err flags; then IDLE.
//   - req_valid is not sampled in DONE; the next instruction is accepted from IDLE the following cycle.
// - stall = (IDLE & req_valid) | REQ | WAIT. stall is 0 in DONE.
// - Latency from the req_valid cycle, with gnt on the first REQ cycle and rvalid on the next:
//   load resp_valid at +3; store at +2; misaligned at +1.
// - resp_rdata holds its last captured value until the next successful load. Stores never change it.
// - rst in any state: IDLE next edge; mem_req low next cycle; in-flight access abandoned
//   (the bus shares rst).
// STRUCTURE
// - lsu_pkg: lsu_state_e enum and the FUNCT3_* load/store localparams. Shared with the alignment block.
// - Sub-module lsu_misalign_check: combinational addr[1:0] + funct3 -> misaligned/illegal.
//   Everything else stays in lsu_mem_ctrl.
// TESTING
// - LW 0x100, gnt on the first REQ cycle, rvalid next with 0xDEADBEEF
//   -> mem_addr=0x100, mem_be=1111; resp_valid at +3 with rdata 0xDEADBEEF; stall high cycles 0-2.
// - SB 0x203, be=1000, wdata=0xAB000000, gnt delayed 4 cycles
//   -> mem_req/addr 0x200/be/wdata stable 5 cycles; one resp_valid; resp_rdata unchanged.
// - LH 0x101 -> resp_valid + misalign_exc at +1; mem_req never asserted. Same for funct3=011.
// - TIMEOUT_CYCLES=8, gnt tied 0 -> bus_err with resp_valid at +9; mem_req low from then on.
// - rst asserted while in WAIT -> next cycle IDLE, stall/mem_req/resp_valid 0, resp_rdata 0;
//   a late rvalid is ignored.
// - LW then SW back-to-back -> exactly two mem_req grants, two resp_valid pulses,
//   no duplicated or lost access.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and load/store funct3 encodings for the LSU data path.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

endpackage

// File: rtl/lsu_misalign_check.sv
// Flags accesses that must not reach the bus: misaligned half/word or an undefined funct3.
module lsu_misalign_check
    import lsu_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  logic [2:0] funct3,
    output logic       bad_access
);

    // Byte accesses are always aligned; halves need addr[0]=0, words need addr[1:0]=0.
    always_comb begin
        bad_access = 1'b0;
        unique case (funct3)
            FUNCT3_B, FUNCT3_BU: bad_access = 1'b0;
            FUNCT3_H, FUNCT3_HU: bad_access = addr_lo[0];
            FUNCT3_W:            bad_access = (addr_lo != 2'b00);
            default:             bad_access = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Data-memory access controller: req/gnt + rvalid bus master with misalign and timeout handling.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        misalign_exc,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_rdata_q, resp_rdata_d;
    logic             misalign_exc_q, misalign_exc_d;
    logic             bus_err_q, bus_err_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic             bad_access;
    logic             timeout;

    lsu_misalign_check u_misalign_check (
        .addr_lo    (req_addr[1:0]),
        .funct3     (req_funct3),
        .bad_access (bad_access)
    );

    assign timeout = (cnt_q == CNT_LAST);

    // Next-state and next-output logic; outputs are registered from the next state.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        resp_rdata_d   = resp_rdata_q;
        misalign_exc_d = 1'b0;
        bus_err_d      = 1'b0;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_be_d       = mem_be_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (bad_access) begin
                        misalign_exc_d = 1'b1;
                        state_d        = ST_DONE;
                    end else begin
                        mem_we_d    = req_write;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wdata_d = req_wdata;
                        mem_be_d    = req_write ? req_be : 4'b1111;
                        cnt_d       = '0;
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // Saturate so a grant on the last cycle leaves WAIT no extra budget.
                cnt_d = timeout ? cnt_q : cnt_q + 1'b1;
                if (mem_gnt) begin
                    state_d = mem_we_q ? ST_DONE : ST_WAIT;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_WAIT: begin
                cnt_d = timeout ? cnt_q : cnt_q + 1'b1;
                if (mem_rvalid) begin
                    resp_rdata_d = mem_rdata;
                    state_d      = ST_DONE;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        mem_req_d    = (state_d == ST_REQ);
        resp_valid_d = (state_d == ST_DONE);
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= '0;
            misalign_exc_q <= 1'b0;
            bus_err_q      <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_be_q       <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            misalign_exc_q <= misalign_exc_d;
            bus_err_q      <= bus_err_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_be_q       <= mem_be_d;
        end
    end

    assign stall        = ((state_q == ST_IDLE) && req_valid) ||
                          (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign misalign_exc = misalign_exc_q;
    assign bus_err      = bus_err_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_be       = mem_be_q;

endmodule
